// File: rtl/prim_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : prim_sram_responder
// Brief    : Flop-array SRAM target with masked writes, fixed-latency reads,
//            zeroing sequence and out-of-range reporting. Optional per-word
//            even parity when PRIM_SRAM_RSP_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module prim_sram_responder #(
  parameter int unsigned SramDw = 32,
  parameter int unsigned SramAw = 12,
  parameter int unsigned Depth  = 1024,
  parameter int unsigned RdLat  = 1,
  parameter bit          EnMask = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sram_req_i,
  input  logic [SramAw-1:0] sram_addr_i,
  input  logic              sram_write_i,
  input  logic [SramDw-1:0] sram_wdata_i,
  input  logic [SramDw-1:0] sram_wmask_i,
  output logic              sram_rvalid_o,
  output logic [SramDw-1:0] sram_rdata_o,
  output logic [1:0]        sram_rerror_o,
`ifdef PRIM_SRAM_RSP_PARITY_EN
  input  logic              inj_par_err_i,
`endif
  input  logic              init_req_i,
  output logic              init_done_o
);

  localparam int unsigned     IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [SramAw:0] c_depth = (SramAw + 1)'(Depth);
  localparam logic [IdxW-1:0] c_last  = IdxW'(Depth - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  if (RdLat < 1) begin : g_bad_rdlat
    $error("prim_sram_responder: RdLat must be at least 1");
  end

  state_e          r_state;
  logic [IdxW-1:0] r_cnt;
  logic            r_init_done;
  logic [SramDw-1:0] r_mem [Depth];

  logic [IdxW-1:0]   w_idx;
  logic              w_in_range;
  logic              w_ready;
  logic              w_wr;
  logic              w_rd;
  logic              w_rd_ok;
  logic [SramDw-1:0] w_mask;
  logic [SramDw-1:0] w_merged;
  logic [SramDw-1:0] w_rdata;
  logic [1:0]        w_rerr;

  assign w_idx      = sram_addr_i[IdxW-1:0];
  assign w_in_range = ({1'b0, sram_addr_i} < c_depth);
  assign w_ready    = (r_state == ST_READY);
  assign w_wr       = sram_req_i & sram_write_i & w_ready & w_in_range;
  assign w_rd       = sram_req_i & ~sram_write_i;
  assign w_rd_ok    = w_rd & w_ready & w_in_range;
  assign w_mask     = EnMask ? sram_wmask_i : '1;
  assign w_merged   = (r_mem[w_idx] & ~w_mask) | (sram_wdata_i & w_mask);
  assign w_rdata    = w_rd_ok ? r_mem[w_idx] : '0;

`ifdef PRIM_SRAM_RSP_PARITY_EN
  logic r_par [Depth];
  logic w_par_bad;

  assign w_par_bad = r_par[w_idx] ^ (^r_mem[w_idx]);
  assign w_rerr    = {~(w_ready & w_in_range), w_rd_ok & w_par_bad};

  always_ff @(posedge clk_i) begin
    if (r_state == ST_INIT) begin
      r_par[r_cnt] <= 1'b0;
    end else if (w_wr) begin
      r_par[w_idx] <= (^w_merged) ^ inj_par_err_i;
    end
  end
`else
  assign w_rerr = {~(w_ready & w_in_range), 1'b0};
`endif

  // Storage is intentionally unreset; INIT zeroing has priority over writes.
  always_ff @(posedge clk_i) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (init_req_i) begin
            r_cnt <= '0;
          end else if (r_cnt == c_last) begin
            r_state <= ST_READY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (init_req_i) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
          end else begin
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Response shift register; idle stages carry zero data and error.
  logic              r_pv [RdLat];
  logic [SramDw-1:0] r_pd [RdLat];
  logic [1:0]        r_pe [RdLat];

  for (genvar s = 0; s < RdLat; s++) begin : g_pipe
    if (s == 0) begin : g_head
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_pv[0] <= 1'b0;
          r_pd[0] <= '0;
          r_pe[0] <= 2'b00;
        end else begin
          r_pv[0] <= w_rd;
          r_pd[0] <= w_rdata;
          r_pe[0] <= w_rd ? w_rerr : 2'b00;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_pv[s] <= 1'b0;
          r_pd[s] <= '0;
          r_pe[s] <= 2'b00;
        end else begin
          r_pv[s] <= r_pv[s-1];
          r_pd[s] <= r_pd[s-1];
          r_pe[s] <= r_pe[s-1];
        end
      end
    end
  end

  assign sram_rvalid_o = r_pv[RdLat-1];
  assign sram_rdata_o  = r_pd[RdLat-1];
  assign sram_rerror_o = r_pe[RdLat-1];
  assign init_done_o   = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_prim_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_sram_responder
// Brief    : Directed bench driving a RdLat=1 and a RdLat=3 responder in step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prim_sram_responder;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          wr;
  logic          init_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] wmask;
`ifdef PRIM_SRAM_RSP_PARITY_EN
  logic          inj;
`endif

  logic          rv1, rv3, done1, done3;
  logic [DW-1:0] rd1, rd3;
  logic [1:0]    re1, re3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prim_sram_responder #(
    .SramDw(DW), .SramAw(AW), .Depth(DEPTH), .RdLat(1), .EnMask(1'b1)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .sram_req_i(req), .sram_addr_i(addr),
    .sram_write_i(wr), .sram_wdata_i(wdata), .sram_wmask_i(wmask),
    .sram_rvalid_o(rv1), .sram_rdata_o(rd1), .sram_rerror_o(re1),
`ifdef PRIM_SRAM_RSP_PARITY_EN
    .inj_par_err_i(inj),
`endif
    .init_req_i(init_req), .init_done_o(done1)
  );

  prim_sram_responder #(
    .SramDw(DW), .SramAw(AW), .Depth(DEPTH), .RdLat(3), .EnMask(1'b1)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .sram_req_i(req), .sram_addr_i(addr),
    .sram_write_i(wr), .sram_wdata_i(wdata), .sram_wmask_i(wmask),
    .sram_rvalid_o(rv3), .sram_rdata_o(rd3), .sram_rerror_o(re3),
`ifdef PRIM_SRAM_RSP_PARITY_EN
    .inj_par_err_i(inj),
`endif
    .init_req_i(init_req), .init_done_o(done3)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    req      = 1'b0;
    wr       = 1'b0;
    init_req = 1'b0;
    addr     = '0;
    wdata    = '0;
    wmask    = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] m);
    req   = 1'b1;
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    wmask = m;
    @(negedge clk);
    idle();
  endtask

  // Issues one read, checks the RdLat=1 response, the idle cycle after it,
  // then the RdLat=3 response two cycles later.
  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] ed,
                         input logic [1:0] ee, input string tag);
    req  = 1'b1;
    wr   = 1'b0;
    addr = a;
    @(negedge clk);
    idle();
    chk({tag, "_v1"}, 64'(rv1), 64'(1));
    chk({tag, "_d1"}, 64'(rd1), 64'(ed));
    chk({tag, "_e1"}, 64'(re1), 64'(ee));
    @(negedge clk);
    chk({tag, "_v1_off"}, 64'(rv1), 64'(0));
    chk({tag, "_d1_off"}, 64'(rd1), 64'(0));
    @(negedge clk);
    chk({tag, "_v3"}, 64'(rv3), 64'(1));
    chk({tag, "_d3"}, 64'(rd3), 64'(ed));
    chk({tag, "_e3"}, 64'(re3), 64'(ee));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
`ifdef PRIM_SRAM_RSP_PARITY_EN
    inj = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", 64'(rv1), 64'(0));
    chk("rst_rdata", 64'(rd1), 64'(0));
    chk("rst_rerror", 64'(re1), 64'(0));
    chk("rst_done", 64'(done1), 64'(0));
    chk("rst_rvalid3", 64'(rv3), 64'(0));

    rst_n = 1'b1;
    repeat (DEPTH) @(negedge clk);
    chk("done_early1", 64'(done1), 64'(0));
    chk("done_early3", 64'(done3), 64'(0));
    @(negedge clk);
    chk("done_rise1", 64'(done1), 64'(1));
    chk("done_rise3", 64'(done3), 64'(1));

    do_read(12'h3FF, 32'h0, 2'b00, "zero_top");
    do_read(12'h000, 32'h0, 2'b00, "zero_bot");

    do_write(12'h010, 32'hDEADBEEF, 32'hFFFFFFFF);
    do_write(12'h010, 32'h00000000, 32'h0000FFFF);
    do_read(12'h010, 32'hDEAD0000, 2'b00, "mask_lo");
    do_write(12'h011, 32'h12345678, 32'hFF00FF00);
    do_read(12'h011, 32'h12005600, 2'b00, "mask_mix");

    do_write(12'h001, 32'h11, 32'hFFFFFFFF);
    do_write(12'h002, 32'h22, 32'hFFFFFFFF);
    do_write(12'h003, 32'h33, 32'hFFFFFFFF);
    for (int i = 0; i < 7; i++) begin
      if (i < 3) begin
        req  = 1'b1;
        wr   = 1'b0;
        addr = AW'(i + 1);
      end else begin
        idle();
      end
      @(negedge clk);
      chk($sformatf("b2b_v1_%0d", i), 64'(rv1), 64'(i < 3));
      chk($sformatf("b2b_d1_%0d", i), 64'(rd1), (i < 3) ? 64'((i + 1) * 32'h11) : 64'(0));
      chk($sformatf("b2b_v3_%0d", i), 64'(rv3), 64'(i >= 2 && i <= 4));
      chk($sformatf("b2b_d3_%0d", i), 64'(rd3),
          (i >= 2 && i <= 4) ? 64'((i - 1) * 32'h11) : 64'(0));
    end

    do_read(12'h400, 32'h0, 2'b10, "oor_400");
    do_read(12'hFFF, 32'h0, 2'b10, "oor_fff");
    do_write(12'h400, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_read(12'h000, 32'h0, 2'b00, "oor_alias");

    // Read in flight across an init request, then a read during INIT.
    req  = 1'b1;
    wr   = 1'b0;
    addr = 12'h001;
    @(negedge clk);
    chk("inflight_v1", 64'(rv1), 64'(1));
    chk("inflight_d1", 64'(rd1), 64'(32'h11));
    req      = 1'b0;
    init_req = 1'b1;
    @(negedge clk);
    chk("init_drop1", 64'(done1), 64'(0));
    chk("init_drop3", 64'(done3), 64'(0));
    init_req = 1'b0;
    req      = 1'b1;
    addr     = 12'h010;
    @(negedge clk);
    idle();
    chk("inflight_v3", 64'(rv3), 64'(1));
    chk("inflight_d3", 64'(rd3), 64'(32'h11));
    chk("inflight_e3", 64'(re3), 64'(0));
    chk("initrd_v1", 64'(rv1), 64'(1));
    chk("initrd_d1", 64'(rd1), 64'(0));
    chk("initrd_e1", 64'(re1), 64'(2'b10));
    @(negedge clk);
    chk("gap_v3", 64'(rv3), 64'(0));
    @(negedge clk);
    chk("initrd_v3", 64'(rv3), 64'(1));
    chk("initrd_d3", 64'(rd3), 64'(0));
    chk("initrd_e3", 64'(re3), 64'(2'b10));

    for (int k = 0; k < 2 * DEPTH && !done1; k++) @(negedge clk);
    chk("reinit_done1", 64'(done1), 64'(1));
    chk("reinit_done3", 64'(done3), 64'(1));
    do_read(12'h001, 32'h0, 2'b00, "reinit_001");
    do_read(12'h010, 32'h0, 2'b00, "reinit_010");

`ifdef PRIM_SRAM_RSP_PARITY_EN
    inj = 1'b1;
    do_write(12'h005, 32'h5, 32'hFFFFFFFF);
    inj = 1'b0;
    do_read(12'h005, 32'h5, 2'b01, "par_inj");
    do_write(12'h005, 32'h5, 32'hFFFFFFFF);
    do_read(12'h005, 32'h5, 2'b00, "par_ok");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
